bcd_timer_ctrl: RTL
===================

Name: bcd_timer_ctrl

Overview:
Run/pause/clear controller that sequences a cascade of BCD digit counters from a programmable prescaler.
- Counts up in BCD at one step per PRESCALE enabled cycles.
- Stops in DONE when the count reaches a programmed BCD limit.
- Flags full-scale wrap with an overflow pulse.
- Sits between front-panel/command logic and the 7-segment display path; count feeds the display directly.

Parameters:
DIGITS, 4, number of cascaded BCD digits (>=1)
PRESCALE, 4, RUN cycles per count step (>=1; 1 = step every RUN cycle)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  level sampled each edge; start/resume/restart command
stop  in  1  level sampled each edge; pause command
clear  in  1  level sampled each edge; return to IDLE with zero count
limit  in  4*DIGITS  BCD terminal value, digit 0 in bits [3:0]
count  out  4*DIGITS  current BCD count, digit 0 in bits [3:0]
running  out  1  high while state==RUN
done  out  1  high while state==DONE
overflow  out  1  one-cycle pulse on wrap from all-9s to all-0s

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, count=0, prescaler=0.
  - running=0, done=0, overflow=0.
  - Release is synchronous to the next clk edge.
- States: IDLE, RUN, PAUSE, DONE. running and done are registered state decodes.
- Command priority: clear > stop > start.
- clear, any state: next state IDLE, count=0, prescaler=0, overflow=0.
- IDLE:
  - start -> RUN, prescaler=0.
  - stop is ignored.
  - If limit==0 at start, go directly to DONE; count stays 0.
- RUN:
  - Each cycle without stop, prescaler increments.
  - When prescaler==PRESCALE-1, count increments by 1 in BCD and prescaler returns to 0 on the same edge.
  - stop -> PAUSE. prescaler and count hold, and no increment occurs on that edge.
  - start is ignored.
- PAUSE:
  - start -> RUN; prescaler resumes from its held value.
  - stop is ignored.
- DONE:
  - count holds.
  - start -> RUN with count=0 and prescaler=0. If limit==0, stay in DONE.
  - stop is ignored.
- Latency: with start sampled at edge E0, the first increment is visible after edge E0+PRESCALE. Each later step occurs every PRESCALE RUN cycles.
- BCD increment:
  - Digit i increments when all lower digits are 9 and the step is enabled.
  - A digit at 9 wraps to 0 and carries; the ripple resolves within one cycle.
  - count only ever holds digit values 0..9.
- Terminal compare:
  - Evaluated on the next-count value at an increment edge.
  - If next count == limit, go to DONE on that same edge; count shows the limit value.
- Overflow:
  - When count is all-9s and increments, count becomes 0 and overflow=1 for exactly that one cycle.
  - If limit==0 on that same step, DONE is also entered.
- Invalid limit: any limit digit >9 never matches; the counter runs and wraps indefinitely.
- Changing limit is allowed at any time. It affects only compares at later increment edges; there is no retroactive DONE.
- Simultaneous start+stop: stop wins in RUN. In IDLE, PAUSE and DONE, stop is ignored, so start takes effect.
- Asynchronous reset mid-count: everything returns to reset values immediately, without waiting for a clock edge.

Decomposition:
- Package bcd_pkg:
  - state encoding constants ST_IDLE/ST_RUN/ST_PAUSE/ST_DONE (2-bit);
  - BCD_MAX=4'd9;
  - BCD_W=4.
- Sub-module bcd_digit, instantiated DIGITS times in a generate loop:
  - ports clk, reset, clr, en, val[3:0], carry;
  - carry = en && val==9;
  - on en: val wraps 9->0, otherwise increments.
- The controller holds the FSM, prescaler, compare logic and overflow register.

Test Plan:
- DIGITS=2, PRESCALE=4. Pulse reset low mid-run with count=07 -> count=00, running=0 immediately, without waiting for a clk edge.
- limit=8'h12, start 1 cycle -> running=1; count steps every 4 cycles (01 after 4th edge); 09->10 rollover; DONE with count=12, done=1, running=0.
- limit=8'h99 (no match before wrap unless equal): run past 99 with limit=8'hAA (invalid) -> at 99->00, overflow=1 for one cycle; keeps counting, done stays 0.
- Pause/resume:
  - stop after 6 RUN cycles: count=01, prescaler=2, holds 20 cycles;
  - start resumes;
  - next step after exactly 2 more cycles.
- Simultaneous commands:
  - clear+stop+start in RUN -> IDLE, count=00;
  - start+stop in RUN -> PAUSE;
  - start with limit=0 in IDLE -> DONE next edge, count=00.
- Restart from DONE:
  - in DONE (count=12), start -> count=00, RUN;
  - PRESCALE=1 build: count increments every cycle, reaching 12 after 12 edges.

Source files
------------

// File: rtl/bcd_pkg.sv
// ============================================================================
// Module : bcd_pkg
// Brief  : Shared BCD digit width, digit maximum, timer states and the
//          single-digit increment helper.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bcd_pkg;

   localparam int BCD_W = 4;
   localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   function automatic logic [BCD_W-1:0] bcd_inc(input logic [BCD_W-1:0] d);
      return (d == BCD_MAX) ? '0 : d + 4'd1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_digit.sv
// ============================================================================
// Module : bcd_digit
// Brief  : One decade of the BCD cascade; carries when stepped at 9.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_digit
   import bcd_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             en,
   output logic [BCD_W-1:0] val,
   output logic             carry
);

   logic [BCD_W-1:0] r_val;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_val <= '0;
      end else if (clr) begin
         r_val <= '0;
      end else if (en) begin
         r_val <= bcd_inc(r_val);
      end
   end

   assign val   = r_val;
   assign carry = en && (r_val == BCD_MAX);

endmodule

`default_nettype wire

// File: rtl/bcd_timer_ctrl.sv
// ============================================================================
// Module : bcd_timer_ctrl
// Brief  : Run/pause/clear controller driving a prescaled BCD digit cascade
//          with terminal-value stop and full-scale overflow pulse.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_timer_ctrl
   import bcd_pkg::*;
#(
   parameter int DIGITS   = 4,
   parameter int PRESCALE = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  stop,
   input  logic                  clear,
   input  logic [4*DIGITS-1:0]   limit,
   output logic [4*DIGITS-1:0]   count,
   output logic                  running,
   output logic                  done,
   output logic                  overflow
);

   localparam int c_presc_w = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [c_presc_w-1:0] c_presc_last = c_presc_w'(PRESCALE - 1);

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [c_presc_w-1:0]   r_presc;
   logic                   r_running;
   logic                   r_done;
   logic                   r_overflow;

   logic                   w_step;
   logic                   w_limit_zero;
   logic                   w_restart;
   logic                   w_clr;
   logic [DIGITS:0]        w_en;
   logic [DIGITS-1:0]      w_carry;
   logic [4*DIGITS-1:0]    w_count;
   logic [4*DIGITS-1:0]    w_next;

   assign w_step       = (r_state == ST_RUN) && !clear && !stop && (r_presc == c_presc_last);
   assign w_limit_zero = (limit == '0);
   assign w_restart    = (r_state == ST_DONE) && start && !w_limit_zero;
   assign w_clr        = clear || w_restart;
   assign w_en[0]      = w_step;

   // w_next mirrors what the digits will hold after this edge, for the terminal compare
   generate
      for (genvar i = 0; i < DIGITS; i++) begin : g_digit
         bcd_digit u_digit (
            .clk   (clk),
            .reset (reset),
            .clr   (w_clr),
            .en    (w_en[i]),
            .val   (w_count[i*BCD_W +: BCD_W]),
            .carry (w_carry[i])
         );
         assign w_en[i+1] = w_carry[i];
         assign w_next[i*BCD_W +: BCD_W] = w_en[i] ? bcd_inc(w_count[i*BCD_W +: BCD_W])
                                                   : w_count[i*BCD_W +: BCD_W];
      end
   endgenerate

   always_comb begin
      w_state_nxt = r_state;
      if (clear) begin
         w_state_nxt = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE:  if (start) w_state_nxt = w_limit_zero ? ST_DONE : ST_RUN;
            ST_RUN: begin
               if (stop)
                  w_state_nxt = ST_PAUSE;
               else if (w_step && (w_next == limit))
                  w_state_nxt = ST_DONE;
            end
            ST_PAUSE: if (start) w_state_nxt = ST_RUN;
            ST_DONE:  if (w_restart) w_state_nxt = ST_RUN;
            default:  w_state_nxt = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= ST_IDLE;
         r_presc    <= '0;
         r_running  <= 1'b0;
         r_done     <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_running  <= (w_state_nxt == ST_RUN);
         r_done     <= (w_state_nxt == ST_DONE);
         r_overflow <= w_en[DIGITS];
         if (clear || w_restart || ((r_state == ST_IDLE) && start)) begin
            r_presc <= '0;
         end else if ((r_state == ST_RUN) && !stop) begin
            r_presc <= (r_presc == c_presc_last) ? '0 : r_presc + c_presc_w'(1);
         end
      end
   end

   assign count    = w_count;
   assign running  = r_running;
   assign done     = r_done;
   assign overflow = r_overflow;

endmodule

`default_nettype wire
